shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 124 ++++++++++++
 tb/tb_shift_unit.sv | 87 ++++++++
 2 files changed

// File: rtl/shift_unit.sv
// shift_unit: iterative single-bit shifter/rotator with carry, three-state FSM.
// Define SHIFT_UNIT_FAST_EN to compute the whole result in one barrel step and skip SHIFT.
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] acc_data,
  input  logic [CNT_W-1:0] shamt,
  input  logic [2:0]       mode,
  input  logic             ci_in,
  output logic [WIDTH-1:0] shift_out,
  output logic             co_out,
  output logic             zero_flag,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic co_q, co_d, zero_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] mode_q, mode_d;
  // One step of the selected mode; result packed as {carry, data}.
  function automatic logic [WIDTH:0] step(input logic [2:0] m, input logic [WIDTH-1:0] d, input logic c);
    logic [WIDTH:0] r;
    case (m)
      3'd0: r = {d, 1'b0};
      3'd1: r = {d[0], 1'b0, d[WIDTH-1:1]};
      3'd2: r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      3'd3: r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      3'd4: r = {d[0], d[0], d[WIDTH-1:1]};
      3'd5: r = {d, c};
      3'd6: r = {d[0], c, d[WIDTH-1:1]};
      default: r = {c, d};
    endcase
    return r;
  endfunction
`ifdef SHIFT_UNIT_FAST_EN
  // Full n-step result in one pass; must match n applications of step().
  function automatic logic [WIDTH:0] barrel(input logic [2:0] m, input logic [WIDTH-1:0] d, input logic c,
                                            input logic [CNT_W-1:0] n);
    logic [WIDTH:0] v, r, lsr;
    logic signed [WIDTH:0] a;
    logic [WIDTH-1:0] rr;
    int rw, rc;
    v   = {c, d};
    rw  = int'(n) % WIDTH;
    rc  = int'(n) % (WIDTH + 1);
    lsr = {d, c} >> n;
    a   = $signed({d, c}) >>> n;
    rr  = '0;
    case (m)
      3'd0: r = v << n;
      3'd1: r = {lsr[0], lsr[WIDTH:1]};
      3'd2: r = {a[0], a[WIDTH:1]};
      3'd3: begin
        rr = (d << rw) | (d >> (WIDTH - rw));
        r  = {(n == '0) ? c : rr[0], rr};
      end
      3'd4: begin
        rr = (d >> rw) | (d << (WIDTH - rw));
        r  = {(n == '0) ? c : rr[WIDTH-1], rr};
      end
      3'd5: r = (v << rc) | (v >> (WIDTH + 1 - rc));
      3'd6: r = (v >> rc) | (v << (WIDTH + 1 - rc));
      default: r = v;
    endcase
    return r;
  endfunction
`endif
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d = mode;
`ifdef SHIFT_UNIT_FAST_EN
        {co_d, data_d} = barrel(mode, acc_data, ci_in, shamt);
        cnt_d   = '0;
        state_d = DONE;
`else
        data_d  = acc_data;
        co_d    = ci_in;
        cnt_d   = shamt;
        state_d = SHIFT;
`endif
      end
      SHIFT: if (cnt_q == '0) state_d = DONE;
        else begin
          {co_d, data_d} = step(mode_q, data_q, co_q);
          cnt_d = cnt_q - 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b1;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      co_q    <= co_d;
      zero_q  <= (data_d == '0);
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end
  assign shift_out = data_q;
  assign co_out    = co_q;
  assign zero_flag = zero_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed vectors for shift_unit at WIDTH=8, either build.
module tb_shift_unit;
`ifdef SHIFT_UNIT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci_in = 1'b0;
  logic [7:0] acc_data = '0;
  logic [3:0] shamt = '0;
  logic [2:0] mode = '0;
  logic [7:0] shift_out;
  logic co_out, zero_flag, busy, done;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  shift_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .acc_data(acc_data), .shamt(shamt),
    .mode(mode), .ci_in(ci_in), .shift_out(shift_out), .co_out(co_out),
    .zero_flag(zero_flag), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] d, input logic [3:0] s,
                        input logic c, input logic [7:0] ed, input logic ec, input bit stray);
    int k, busy_n;
    k = 0;
    busy_n = 0;
    @(negedge clk);
    mode = m; acc_data = d; shamt = s; ci_in = c; start = 1'b1;
    do begin
      @(negedge clk);
      k++;
      if (busy && !done) busy_n++;
      if (stray && k == 1) begin
        start = 1'b1; acc_data = ~d; mode = 3'b100; shamt = 4'd1; ci_in = ~c;
      end else start = 1'b0;
    end while (!done && k < 40);
    chk({tag, ".latency"}, k, FAST ? 1 : s + 2);
    chk({tag, ".shift_out"}, shift_out, ed);
    chk({tag, ".co_out"}, co_out, ec);
    chk({tag, ".zero_flag"}, zero_flag, ed == 8'h00);
    chk({tag, ".busy_cycles"}, busy_n, FAST ? 0 : s + 1);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_pulse"}, {busy, done}, 2'b00);
    chk({tag, ".held"}, {co_out, shift_out}, {ec, ed});
  endtask
  initial begin
    int dn;
    repeat (2) @(negedge clk);
    chk("reset", {shift_out, co_out, zero_flag, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    run_op("lsl",      3'd0, 8'h81, 4'd1, 1'b0, 8'h02, 1'b1, 1'b0);
    run_op("asr",      3'd2, 8'h80, 4'd3, 1'b0, 8'hF0, 1'b0, 1'b0);
    run_op("ror9",     3'd4, 8'h01, 4'd9, 1'b0, 8'h80, 1'b1, 1'b0);
    run_op("rcl",      3'd5, 8'h80, 4'd1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("shamt0",   3'd0, 8'hA5, 4'd0, 1'b1, 8'hA5, 1'b1, 1'b0);
    run_op("lsr9",     3'd1, 8'h81, 4'd9, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("rcr",      3'd6, 8'h01, 4'd2, 1'b1, 8'hC0, 1'b0, 1'b0);
    run_op("rol",      3'd3, 8'h81, 4'd1, 1'b0, 8'h03, 1'b1, 1'b0);
    run_op("hold",     3'd7, 8'h3C, 4'd5, 1'b1, 8'h3C, 1'b1, 1'b0);
    run_op("asr12",    3'd2, 8'h90, 4'd12, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("stray",    3'd0, 8'h81, 4'd3, 1'b0, 8'h08, 1'b0, 1'b1);
    @(negedge clk);
    mode = 3'd0; acc_data = 8'h81; shamt = 4'd5; ci_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort.reset", {shift_out, co_out, zero_flag, busy, done}, {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("abort.no_done", dn, 0);
    run_op("after_rst", 3'd1, 8'h81, 4'd1, 1'b1, 8'h40, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
